// File: rtl/riscv_defines.sv
// Shared types and widths for the registered execute stage and its MDU.
package riscv_defines;

    localparam int WORD_WIDTH   = 32;
    localparam int ALU_OP_WIDTH = 4;

    // RV32M operation, funct3 encoding
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // ALU op: {funct7[5], funct3}, so bits [2:0] double as the MDU op
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide,
// MDU_UNROLL bits per cycle. Result is valid while done_o is high.
module mdu_iter #(
    parameter int WORD_WIDTH = 32,
    parameter int MDU_UNROLL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WORD_WIDTH-1:0] result_o
);
    import riscv_defines::*;

    localparam int STEPS = WORD_WIDTH / MDU_UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(STEPS);
    localparam logic [WORD_WIDTH-1:0] MIN_VAL  = {1'b1, {(WORD_WIDTH-1){1'b0}}};

    mdu_state_e state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    mdu_op_e               op_q, op_d;
    logic                  quo_neg_q, quo_neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic [WORD_WIDTH:0]   hi_q, hi_d;
    logic [WORD_WIDTH-1:0] lo_q, lo_d;
    logic [WORD_WIDTH-1:0] dsr_q, dsr_d;

    mdu_op_e               op_in;
    logic                  is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [WORD_WIDTH-1:0] a_mag, b_mag;
    logic [WORD_WIDTH:0]   step_hi;
    logic [WORD_WIDTH-1:0] step_lo;
    logic [2*WORD_WIDTH-1:0] prod, prod_s;

    assign op_in    = mdu_op_e'(op_i);
    assign is_div   = op_i[2];
    assign a_signed = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                      (op_in == MDU_DIV)  || (op_in == MDU_REM);
    assign b_signed = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
    assign a_neg    = a_signed && a_i[WORD_WIDTH-1];
    assign b_neg    = b_signed && b_i[WORD_WIDTH-1];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign div_zero = is_div && (b_i == '0);
    assign div_ovf  = is_div && a_signed && (a_i == MIN_VAL) && (b_i == '1);

    // One iteration group: MDU_UNROLL multiply or divide steps on {hi, lo}
    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        for (int u = 0; u < MDU_UNROLL; u++) begin
            if (op_q[2]) begin
                step_hi = {step_hi[WORD_WIDTH-1:0], step_lo[WORD_WIDTH-1]};
                step_lo = {step_lo[WORD_WIDTH-2:0], 1'b0};
                if (step_hi >= {1'b0, dsr_q}) begin
                    step_hi    = step_hi - {1'b0, dsr_q};
                    step_lo[0] = 1'b1;
                end
            end else begin
                if (step_lo[0]) begin
                    step_hi = step_hi + {1'b0, dsr_q};
                end
                step_lo = {step_hi[0], step_lo[WORD_WIDTH-1:1]};
                step_hi = {1'b0, step_hi[WORD_WIDTH:1]};
            end
        end
    end

    // FSM next state plus operand/accumulator updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dsr_d     = dsr_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d = op_in;
                    if (div_zero) begin
                        // quotient all ones, remainder is the raw dividend
                        hi_d      = {1'b0, a_i};
                        lo_d      = '1;
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = FIX;
                    end else if (div_ovf) begin
                        hi_d      = '0;
                        lo_d      = MIN_VAL;
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = FIX;
                    end else begin
                        hi_d      = '0;
                        lo_d      = is_div ? a_mag : b_mag;
                        dsr_d     = is_div ? b_mag : a_mag;
                        quo_neg_d = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        cnt_d     = CNT_INIT;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath registers; only read in CALC/FIX, so no reset needed
    always_ff @(posedge clk) begin
        op_q      <= op_d;
        quo_neg_q <= quo_neg_d;
        rem_neg_q <= rem_neg_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
        dsr_q     <= dsr_d;
    end

    assign prod   = {hi_q[WORD_WIDTH-1:0], lo_q};
    assign prod_s = quo_neg_q ? -prod : prod;

    // Sign correction and half/quotient/remainder selection
    always_comb begin
        result_o = '0;
        case (op_q)
            MDU_MUL:                           result_o = prod_s[WORD_WIDTH-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:   result_o = prod_s[2*WORD_WIDTH-1:WORD_WIDTH];
            MDU_DIV, MDU_DIVU:                 result_o = quo_neg_q ? -lo_q : lo_q;
            MDU_REM, MDU_REMU:                 result_o = rem_neg_q ? -hi_q[WORD_WIDTH-1:0]
                                                                    : hi_q[WORD_WIDTH-1:0];
            default:                           result_o = '0;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == FIX);

endmodule

// File: rtl/ex_stage_mc.sv
// Registered execute stage: immediates, ALU, branch/jump resolution,
// optional iterative MDU and a valid/ready EX/WB output register.
module ex_stage_mc #(
    parameter int WORD_WIDTH   = 32,
    parameter int RISCV_M_CORE = 1,
    parameter int MDU_UNROLL   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   id_valid_i,
    output logic                                   ex_ready_o,
    input  logic [WORD_WIDTH-1:0]                  reg_rdata1_i,
    input  logic [WORD_WIDTH-1:0]                  reg_rdata2_i,
    input  logic [31:0]                            instruction_i,
    input  logic [WORD_WIDTH-1:0]                  program_count_i,
    input  logic [riscv_defines::ALU_OP_WIDTH-1:0] alu_op_ctrl_i,
    input  logic                                   stype_imm_mux_i,
    input  logic                                   auipc_flag_i,
    input  logic                                   imm_alu_mux_i,
    input  logic                                   jalr_flag_i,
    input  logic                                   jal_flag_i,
    input  logic                                   branch_flag_i,
    input  logic                                   lui_alu_bypass_i,
    input  logic                                   zeroflag_inv_i,
    input  logic                                   alu_mdu_mux_i,
    input  logic                                   wb_ready_i,
    output logic                                   wb_valid_o,
    output logic [WORD_WIDTH-1:0]                  wb_data_o,
    output logic [4:0]                             reg_waddr_o,
    output logic                                   pc_branch_ctrl_o,
    output logic [WORD_WIDTH-1:0]                  pc_branch_addr_o
);
    import riscv_defines::*;

    localparam int SHW = $clog2(WORD_WIDTH);
    localparam logic [WORD_WIDTH-1:0] LSB_CLR = {{(WORD_WIDTH-1){1'b1}}, 1'b0};

    logic [WORD_WIDTH-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sel;
    logic [WORD_WIDTH-1:0] op_a, op_b, alu_res, alu_wb, redir_addr, mdu_res;
    logic signed [WORD_WIDTH-1:0] op_a_s, op_b_s;
    logic [SHW-1:0] shamt;
    logic br_taken, redir, accept, is_mdu, mdu_start, mdu_busy, mdu_done;
    logic unused_opcode;

    logic                  wb_valid_q, wb_valid_d;
    logic [WORD_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]            reg_waddr_q, reg_waddr_d;
    logic [4:0]            rd_pend_q, rd_pend_d;
    logic                  redir_q, redir_d;
    logic [WORD_WIDTH-1:0] redir_addr_q, redir_addr_d;

    assign unused_opcode = ^instruction_i[6:0];

    assign imm_i = WORD_WIDTH'($signed(instruction_i[31:20]));
    assign imm_s = WORD_WIDTH'($signed({instruction_i[31:25], instruction_i[11:7]}));
    assign imm_b = WORD_WIDTH'($signed({instruction_i[31], instruction_i[7],
                                        instruction_i[30:25], instruction_i[11:8], 1'b0}));
    assign imm_j = WORD_WIDTH'($signed({instruction_i[31], instruction_i[19:12],
                                        instruction_i[20], instruction_i[30:21], 1'b0}));
    assign imm_u = WORD_WIDTH'($signed({instruction_i[31:12], 12'b0}));

    assign imm_sel = auipc_flag_i ? imm_u : (stype_imm_mux_i ? imm_s : imm_i);
    assign op_a    = auipc_flag_i ? program_count_i : reg_rdata1_i;
    assign op_b    = imm_alu_mux_i ? imm_sel : reg_rdata2_i;
    assign op_a_s  = op_a;
    assign op_b_s  = op_b;
    assign shamt   = op_b[SHW-1:0];

    // ALU
    always_comb begin
        alu_res = '0;
        case (alu_op_e'(alu_op_ctrl_i))
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = {{(WORD_WIDTH-1){1'b0}}, op_a_s < op_b_s};
            ALU_SLTU: alu_res = {{(WORD_WIDTH-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = op_a_s >>> shamt;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            default:  alu_res = op_a + op_b;
        endcase
    end

    assign alu_wb     = lui_alu_bypass_i ? imm_u
                      : ((jal_flag_i || jalr_flag_i) ? program_count_i + WORD_WIDTH'(4) : alu_res);
    assign br_taken   = branch_flag_i && ((alu_res == '0) ^ zeroflag_inv_i);
    assign redir      = br_taken || jal_flag_i || jalr_flag_i;
    assign redir_addr = jalr_flag_i ? ((reg_rdata1_i + imm_i) & LSB_CLR)
                                    : program_count_i + (jal_flag_i ? imm_j : imm_b);

    assign ex_ready_o = !mdu_busy && (!wb_valid_q || wb_ready_i);
    assign accept     = id_valid_i && ex_ready_o;
    assign is_mdu     = (RISCV_M_CORE != 0) && alu_mdu_mux_i;
    assign mdu_start  = accept && is_mdu;

    generate
        if (RISCV_M_CORE != 0) begin : g_mdu
            mdu_iter #(
                .WORD_WIDTH (WORD_WIDTH),
                .MDU_UNROLL (MDU_UNROLL)
            ) u_mdu (
                .clk      (clk),
                .rst_n    (rst_n),
                .start_i  (mdu_start),
                .op_i     (alu_op_ctrl_i[2:0]),
                .a_i      (reg_rdata1_i),
                .b_i      (reg_rdata2_i),
                .busy_o   (mdu_busy),
                .done_o   (mdu_done),
                .result_o (mdu_res)
            );
        end else begin : g_no_mdu
            assign mdu_busy = 1'b0;
            assign mdu_done = 1'b0;
            assign mdu_res  = '0;
        end
    endgenerate

    // EX/WB register: ALU load on accept, MDU load on done, hold while stalled
    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_data_d    = wb_data_q;
        reg_waddr_d  = reg_waddr_q;
        redir_d      = redir_q;
        redir_addr_d = redir_addr_q;
        rd_pend_d    = mdu_start ? instruction_i[11:7] : rd_pend_q;
        if (accept && !is_mdu) begin
            wb_valid_d   = 1'b1;
            wb_data_d    = alu_wb;
            reg_waddr_d  = instruction_i[11:7];
            redir_d      = redir;
            redir_addr_d = redir_addr;
        end else if (mdu_done) begin
            wb_valid_d   = 1'b1;
            wb_data_d    = mdu_res;
            reg_waddr_d  = rd_pend_q;
            redir_d      = 1'b0;
            redir_addr_d = '0;
        end else if (wb_ready_i) begin
            wb_valid_d   = 1'b0;
            redir_d      = 1'b0;
        end
    end

    // Output register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            reg_waddr_q  <= '0;
            rd_pend_q    <= '0;
            redir_q      <= 1'b0;
            redir_addr_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            reg_waddr_q  <= reg_waddr_d;
            rd_pend_q    <= rd_pend_d;
            redir_q      <= redir_d;
            redir_addr_q <= redir_addr_d;
        end
    end

    assign wb_valid_o       = wb_valid_q;
    assign wb_data_o        = wb_data_q;
    assign reg_waddr_o      = reg_waddr_q;
    assign pc_branch_ctrl_o = redir_q;
    assign pc_branch_addr_o = redir_addr_q;

endmodule
